mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control unit for the MIPS core; replaces the single-cycle combinational controller once the datapath shares one memory port and one ALU across cycles.
- Decodes OPC/func from the instruction register and sequences fetch, decode, execute, memory and writeback states.
- Stalls on a memory-ready handshake.
- Drives every datapath mux select and write enable. The datapath itself is unchanged apart from IR/A/B/ALUOut/MDR registers.

Parameters:
- OPW, 6, opcode and func field width.
- ALUW, 3, ALUOperation width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- OPC  in  6  instruction [31:26], taken from the IR.
- func  in  6  instruction [5:0], taken from the IR.
- z  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- PCWrite  out  1  final PC load enable, branch condition already folded in.
- PCSrc  out  2  next-PC select: 00=ALU, 01=ALUOut, 10=jump target, 11=register A.
- ALUSrcA  out  1  ALU A select: 0=PC, 1=register A.
- ALUSrcB  out  2  ALU B select: 00=B, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate<<2.
- ALUOperation  out  3  ALU operation: 010=add, 110=sub, 000=and, 001=or, 111=slt.
- RegDst  out  2  write register select: 00=rt, 01=rd, 10=$31.
- MemtoReg  out  2  write data select: 00=ALUOut, 01=MDR, 10=PC.
- RegWrite  out  1  register file write enable.
- illegal  out  1  one-cycle pulse when an unknown opcode/func is decoded.

Behaviour:
- Reset is asynchronous and active-low. Asserting rst_n=0 forces state to RST.
- RST state: all outputs 0. The state moves to FETCH on the first clk edge after rst_n rises.
- Reset asserted mid-instruction aborts that instruction; no write enable fires after reset asserts.
- Outputs are Moore (decoded from the state) except IRWrite, PCWrite and illegal, which are qualified as noted below.
- FETCH:
  - Drives IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, add, so the branch target lands in ALUOut.
  - Next state by opcode:
    - 000000 with func 001000 (jr) -> JR.
    - 000000 with func in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} -> EXEC_R.
    - 100011 lw or 101011 sw -> MEM_ADDR.
    - 000100 beq or 000101 bne -> BRANCH.
    - 001000 addi -> EXEC_I.
    - 001010 slti -> EXEC_I.
    - 000010 j -> JUMP.
    - 000011 jal -> JAL.
    - Anything else -> FETCH, with illegal=1 for that DECODE cycle.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOperation taken from func -> RWB.
- RWB: RegDst=01, MemtoReg=00, RegWrite=1 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, add for addi or slt for slti -> IWB.
- IWB: RegDst=00, MemtoReg=00, RegWrite=1 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD=1, MemRead=1; waits for mem_ready=1 -> MEM_WB.
- MEM_WB: RegDst=00, MemtoReg=01, RegWrite=1 -> FETCH.
- MEM_WR: IorD=1, MemWrite=1; waits for mem_ready=1 -> FETCH.
- Memory requests are held stable while stalled.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01.
  - PCWrite=(beq&z)|(bne&~z).
  - -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- JAL: PCSrc=10, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1 -> FETCH. The datapath writes the PC value held before the update, which is already PC+4.
- JR: PCSrc=11, PCWrite=1 -> FETCH.
- Cycle counts with zero wait states:
  - 3 cycles: j, jal, jr, beq, bne.
  - 4 cycles: R-type, addi, slti, sw.
  - 5 cycles: lw.
  - Each wait cycle adds 1.
- The state register uses an enum. Any unreachable encoding recovers to FETCH.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs cycle_cnt and instr_cnt. Both reset to 0.
  - cycle_cnt increments every non-RST cycle.
  - instr_cnt increments on each DECODE cycle with a legal opcode.
  - Both wrap modulo 2^32.
- Undefined: no counter logic and no ports. Control behaviour is identical in both builds.

Decomposition:
- Package mips_pkg:
  - state_t enum.
  - Opcode and func localparams.
  - ALU operation codes.
  - PCSrc/ALUSrcB/RegDst/MemtoReg select encodings.
- Sub-module mc_alu_decode: combinational func/state to ALUOperation decode.
- FSM, output decode and perf counters stay in mc_controller.

Test Plan:
- Reset, then release rst_n with mem_ready=1 -> RST outputs all 0; FETCH next cycle with MemRead=1, IRWrite=1, PCWrite=1.
- Instruction 0x8C080004 (lw $8,4($0)), mem_ready held 0 for 2 cycles in MEM_RD -> MemRead/IorD held high; RegWrite=1 with MemtoReg=01 exactly 7 cycles after FETCH entry.
- beq with z=1, then beq with z=0 -> PCWrite=1 with PCSrc=01 in the first BRANCH cycle, PCWrite=0 in the second; both return to FETCH.
- jal 0x0C000010 -> JAL cycle asserts PCWrite=1, PCSrc=10, RegDst=10, MemtoReg=10, RegWrite=1.
- Opcode 111111 -> illegal pulses exactly 1 cycle in DECODE; next state FETCH; no RegWrite/MemWrite asserted.
- rst_n dropped during MEM_WR -> MemWrite falls asynchronously before the next clk edge. With MC_PERF_CNT_EN defined, cycle_cnt and instr_cnt both read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/func
// values, ALU operation codes and datapath mux select encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        StRst,
        StFetch,
        StDecode,
        StExecR,
        StRwb,
        StExecI,
        StIwb,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StBranch,
        StJump,
        StJal,
        StJr
    } state_t;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnJr  = 6'b001000;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;
    localparam logic [1:0] PcSrcRegA   = 2'b11;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDstRa = 2'b10;

    localparam logic [1:0] MemtoRegAlu = 2'b00;
    localparam logic [1:0] MemtoRegMdr = 2'b01;
    localparam logic [1:0] MemtoRegPc  = 2'b10;

    // StFetch doubles as the "unknown instruction" marker.
    function automatic state_t decode_next(input logic [5:0] opc, input logic [5:0] fn);
        state_t nxt;
        nxt = StFetch;
        case (opc)
            OpRtype: begin
                if (fn == FnJr) begin
                    nxt = StJr;
                end else if (fn inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt}) begin
                    nxt = StExecR;
                end
            end
            OpLw, OpSw:     nxt = StMemAddr;
            OpBeq, OpBne:   nxt = StBranch;
            OpAddi, OpSlti: nxt = StExecI;
            OpJ:            nxt = StJump;
            OpJal:          nxt = StJal;
            default:        nxt = StFetch;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALUOperation decode from the controller state, opcode and func.
module mc_alu_decode
    import mips_pkg::*;
#(
    parameter int unsigned OPW  = 6,
    parameter int unsigned ALUW = 3
) (
    input  state_t          state,
    input  logic [OPW-1:0]  OPC,
    input  logic [OPW-1:0]  func,
    output logic [ALUW-1:0] alu_op
);

    always_comb begin
        alu_op = '0;
        case (state)
            StFetch, StDecode, StMemAddr: alu_op = AluAdd;
            StExecR: begin
                case (func)
                    FnSub:   alu_op = AluSub;
                    FnAnd:   alu_op = AluAnd;
                    FnOr:    alu_op = AluOr;
                    FnSlt:   alu_op = AluSlt;
                    default: alu_op = AluAdd;
                endcase
            end
            StExecI:  alu_op = (OPC == OpSlti) ? AluSlt : AluAdd;
            StBranch: alu_op = AluSub;
            default:  alu_op = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback.
// Define MC_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_controller
    import mips_pkg::*;
#(
    parameter int unsigned OPW  = 6,
    parameter int unsigned ALUW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  OPC,
    input  logic [OPW-1:0]  func,
    input  logic            z,
    input  logic            mem_ready,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic [1:0]      PCSrc,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [ALUW-1:0] ALUOperation,
    output logic [1:0]      RegDst,
    output logic [1:0]      MemtoReg,
    output logic            RegWrite,
    output logic            illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instr_cnt
`endif
);

    state_t state;
    state_t decoded_next;

    assign decoded_next = decode_next(OPC, func);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StRst;
        end else begin
            case (state)
                StRst:     state <= StFetch;
                StFetch:   if (mem_ready) state <= StDecode;
                StDecode:  state <= decoded_next;
                StExecR:   state <= StRwb;
                StExecI:   state <= StIwb;
                StMemAddr: state <= (OPC == OpLw) ? StMemRd : StMemWr;
                StMemRd:   if (mem_ready) state <= StMemWb;
                StMemWr:   if (mem_ready) state <= StFetch;
                StRwb, StIwb, StMemWb, StBranch, StJump, StJal, StJr: state <= StFetch;
                default:   state <= StFetch;
            endcase
        end
    end

    mc_alu_decode #(
        .OPW  (OPW),
        .ALUW (ALUW)
    ) u_alu_decode (
        .state  (state),
        .OPC    (OPC),
        .func   (func),
        .alu_op (ALUOperation)
    );

    // Decoded straight from the state so an asynchronous reset drops every enable at once.
    always_comb begin
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = PcSrcAlu;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SrcBReg;
        RegDst   = RegDstRt;
        MemtoReg = MemtoRegAlu;
        RegWrite = 1'b0;
        illegal  = 1'b0;
        case (state)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = SrcBFour;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            StDecode: begin
                ALUSrcB = SrcBImmSh;
                illegal = (decoded_next == StFetch);
            end
            StExecR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBReg;
            end
            StRwb: begin
                RegDst   = RegDstRd;
                RegWrite = 1'b1;
            end
            StExecI, StMemAddr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
            end
            StIwb: RegWrite = 1'b1;
            StMemRd: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            StMemWb: begin
                MemtoReg = MemtoRegMdr;
                RegWrite = 1'b1;
            end
            StMemWr: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            StBranch: begin
                ALUSrcA = 1'b1;
                PCSrc   = PcSrcAluOut;
                PCWrite = ((OPC == OpBeq) && z) || ((OPC == OpBne) && !z);
            end
            StJump: begin
                PCSrc   = PcSrcJump;
                PCWrite = 1'b1;
            end
            StJal: begin
                PCSrc    = PcSrcJump;
                PCWrite  = 1'b1;
                RegDst   = RegDstRa;
                MemtoReg = MemtoRegPc;
                RegWrite = 1'b1;
            end
            StJr: begin
                PCSrc   = PcSrcRegA;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != StRst) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if ((state == StDecode) && (decoded_next != StFetch)) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller; outputs are packed into one vector
// and compared under a per-state care mask against hand-written expected values.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] OPC;
    logic [5:0] func;
    logic       z;
    logic       mem_ready;
    logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, ALUSrcA, RegWrite, illegal;
    logic [1:0] PCSrc, ALUSrcB, RegDst, MemtoReg;
    logic [2:0] ALUOperation;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .OPC          (OPC),
        .func         (func),
        .z            (z),
        .mem_ready    (mem_ready),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .PCSrc        (PCSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOperation (ALUOperation),
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .illegal      (illegal)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt)
`endif
    );

    // [18]IorD [17]MemRead [16]MemWrite [15]IRWrite [14]PCWrite [13:12]PCSrc [11]ALUSrcA
    // [10:9]ALUSrcB [8:6]ALUOperation [5:4]RegDst [3:2]MemtoReg [1]RegWrite [0]illegal
    logic [18:0] outs;
    assign outs = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
                   ALUOperation, RegDst, MemtoReg, RegWrite, illegal};

    localparam logic [18:0] M_EN    = 19'b0111_1000_0000_0000_011;
    localparam logic [18:0] M_IORD  = 19'b1000_0000_0000_0000_000;
    localparam logic [18:0] M_PCSRC = 19'b0000_0110_0000_0000_000;
    localparam logic [18:0] M_SRCA  = 19'b0000_0001_0000_0000_000;
    localparam logic [18:0] M_SRCB  = 19'b0000_0000_1100_0000_000;
    localparam logic [18:0] M_ALU   = 19'b0000_0000_0011_1000_000;
    localparam logic [18:0] M_DST   = 19'b0000_0000_0000_0110_000;
    localparam logic [18:0] M_M2R   = 19'b0000_0000_0000_0001_100;
    localparam logic [18:0] M_ALL   = 19'h7FFFF;

    localparam logic [18:0] M_FETCH  = M_EN | M_IORD | M_PCSRC | M_SRCA | M_SRCB | M_ALU;
    localparam logic [18:0] M_DECODE = M_EN | M_SRCA | M_SRCB | M_ALU;

    function automatic logic [18:0] v(input logic iord, input logic mr, input logic mw,
                                      input logic irw, input logic pcw, input logic [1:0] pcsrc,
                                      input logic srca, input logic [1:0] srcb,
                                      input logic [2:0] alu, input logic [1:0] dst,
                                      input logic [1:0] m2r, input logic rw, input logic ill);
        return {iord, mr, mw, irw, pcw, pcsrc, srca, srcb, alu, dst, m2r, rw, ill};
    endfunction

    function automatic logic [18:0] fetch_v(input logic rdy);
        return v(1'b0, 1'b1, 1'b0, rdy, rdy, 2'b00, 1'b0, 2'b01, 3'b010, 2'b00, 2'b00,
                 1'b0, 1'b0);
    endfunction

    function automatic logic [18:0] decode_v(input logic ill);
        return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 3'b010, 2'b00, 2'b00,
                 1'b0, ill);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [18:0] exp, input logic [18:0] care);
        #1;
        checks++;
        assert ((outs & care) === (exp & care)) else begin
            errors++;
            $error("FAIL %s: observed=%05h expected=%05h care=%05h", tag, outs & care,
                   exp & care, care);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        OPC       = 6'h00;
        func      = 6'h00;
        z         = 1'b0;
        mem_ready = 1'b1;
        step();
        step();
        chk("rst", 19'h0, M_ALL);

        // Release: one more RST cycle, then FETCH.
        rst_n = 1'b1;
        chk("rst_hold", 19'h0, M_ALL);
        step();
        chk("fetch_first", fetch_v(1'b1), M_FETCH);

        // lw $8,4($0) = 0x8C080004 with two wait states in MEM_RD.
        step();
        OPC = 6'b100011; func = 6'b000100;
        chk("lw_decode", decode_v(1'b0), M_DECODE);
        step();
        mem_ready = 1'b0;
        chk("lw_memaddr", v(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 2'b00, 2'b00, 0, 0),
            M_DECODE);
        step();
        chk("lw_memrd_w1", v(1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0),
            M_EN | M_IORD);
        step();
        chk("lw_memrd_w2", v(1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0),
            M_EN | M_IORD);
        step();
        mem_ready = 1'b1;
        chk("lw_memrd_rdy", v(1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0),
            M_EN | M_IORD);
        step();
        // Seventh cycle counting the FETCH cycle as the first.
        chk("lw_memwb", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 2'b01, 1, 0),
            M_EN | M_DST | M_M2R);
        step();
        chk("lw_fetch", fetch_v(1'b1), M_FETCH);

        // beq taken.
        step();
        OPC = 6'b000100; func = 6'b000000;
        chk("beq1_decode", decode_v(1'b0), M_DECODE);
        step();
        z = 1'b1;
        chk("beq_taken", v(0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b110, 2'b00, 2'b00, 0, 0),
            M_EN | M_PCSRC | M_SRCA | M_SRCB | M_ALU);
        step();
        chk("beq1_fetch", fetch_v(1'b1), M_FETCH);

        // beq not taken.
        step();
        chk("beq2_decode", decode_v(1'b0), M_DECODE);
        step();
        z = 1'b0;
        chk("beq_not_taken", v(0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b110, 2'b00, 2'b00, 0, 0),
            M_EN | M_PCSRC | M_SRCA | M_SRCB | M_ALU);
        step();
        chk("beq2_fetch", fetch_v(1'b1), M_FETCH);

        // bne with z=1 must not branch.
        step();
        OPC = 6'b000101;
        chk("bne_decode", decode_v(1'b0), M_DECODE);
        step();
        z = 1'b1;
        chk("bne_not_taken", v(0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b110, 2'b00, 2'b00, 0, 0),
            M_EN | M_PCSRC | M_SRCA | M_SRCB | M_ALU);
        step();
        z = 1'b0;
        chk("bne_fetch", fetch_v(1'b1), M_FETCH);

        // R-type sub.
        step();
        OPC = 6'b000000; func = 6'b100010;
        chk("sub_decode", decode_v(1'b0), M_DECODE);
        step();
        chk("sub_exec", v(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b110, 2'b00, 2'b00, 0, 0),
            M_DECODE);
        step();
        chk("sub_rwb", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 2'b01, 2'b00, 1, 0),
            M_EN | M_DST | M_M2R);
        step();
        chk("sub_fetch", fetch_v(1'b1), M_FETCH);

        // slti.
        step();
        OPC = 6'b001010; func = 6'b000111;
        chk("slti_decode", decode_v(1'b0), M_DECODE);
        step();
        chk("slti_exec", v(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b111, 2'b00, 2'b00, 0, 0),
            M_DECODE);
        step();
        chk("slti_iwb", v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 2'b00, 1, 0),
            M_EN | M_DST | M_M2R);
        step();
        chk("slti_fetch", fetch_v(1'b1), M_FETCH);

        // Fetch stall: no IR/PC load and no advance while memory is busy.
        mem_ready = 1'b0;
        chk("fetch_stall1", fetch_v(1'b0), M_FETCH);
        step();
        chk("fetch_stall2", fetch_v(1'b0), M_FETCH);
        mem_ready = 1'b1;
        chk("fetch_go", fetch_v(1'b1), M_FETCH);

        // jal 0x0C000010.
        step();
        OPC = 6'b000011; func = 6'b010000;
        chk("jal_decode", decode_v(1'b0), M_DECODE);
        step();
        chk("jal", v(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 2'b10, 2'b10, 1, 0),
            M_EN | M_PCSRC | M_DST | M_M2R);
        step();
        chk("jal_fetch", fetch_v(1'b1), M_FETCH);

        // jr.
        step();
        OPC = 6'b000000; func = 6'b001000;
        chk("jr_decode", decode_v(1'b0), M_DECODE);
        step();
        chk("jr", v(0, 0, 0, 0, 1, 2'b11, 0, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0),
            M_EN | M_PCSRC);
        step();
        chk("jr_fetch", fetch_v(1'b1), M_FETCH);

        // Unknown opcode: single illegal pulse, straight back to FETCH.
        step();
        OPC = 6'b111111; func = 6'b000000;
        chk("illegal_decode", decode_v(1'b1), M_DECODE);
        step();
        chk("illegal_fetch", fetch_v(1'b1), M_FETCH);

        // sw stalled in MEM_WR, then reset asserted mid-cycle.
        step();
        OPC = 6'b101011; func = 6'b000000;
        chk("sw_decode", decode_v(1'b0), M_DECODE);
        step();
        mem_ready = 1'b0;
        chk("sw_memaddr", v(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 2'b00, 2'b00, 0, 0),
            M_DECODE);
        step();
        chk("sw_memwr", v(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0),
            M_EN | M_IORD);
        rst_n = 1'b0;
        chk("rst_async", 19'h0, M_ALL);
`ifdef MC_PERF_CNT_EN
        chk32("cycle_cnt_rst", cycle_cnt, 32'd0);
        chk32("instr_cnt_rst", instr_cnt, 32'd0);
`endif
        step();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        chk("rst_release", 19'h0, M_ALL);
        step();
        chk("fetch_after_rst", fetch_v(1'b1), M_FETCH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
